// File: rtl/telem_pkt_tx_if.sv
// ============================================================================
//  Module      : telem_pkt_tx_if
//  Description : Bundles the signals of the telemetry packet transmitter.
//                Request side: send_req, pyld_a, pyld_b, busy, pkt_done.
//                UART side   : trmt, tx_data, tx_done.
//                master - the requester / UART environment
//                slave  - the packet transmitter (telem_pkt_tx)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface telem_pkt_tx_if;
    logic        send_req;   // request one packet
    logic [15:0] pyld_a;     // payload word A
    logic [15:0] pyld_b;     // payload word B
    logic        tx_done;    // UART byte-complete level
    logic        trmt;       // one-cycle start strobe to the UART
    logic [7:0]  tx_data;    // byte presented to the UART
    logic        busy;       // packet in progress
    logic        pkt_done;   // one-cycle packet completion pulse

    modport master (
        output send_req, pyld_a, pyld_b, tx_done,
        input  trmt, tx_data, busy, pkt_done
    );

    modport slave (
        input  send_req, pyld_a, pyld_b, tx_done,
        output trmt, tx_data, busy, pkt_done
    );
endinterface

`default_nettype wire

// File: rtl/telem_pkt_tx.sv
// ============================================================================
//  Module      : telem_pkt_tx
//  Description : Serialises a telemetry packet (two header bytes followed by
//                two captured 16-bit payload words, MSB first) into a
//                byte-at-a-time UART transmitter handshake.
//                Compile-time option TELEM_CHKSUM_EN appends a seventh byte:
//                the two's complement of the 8-bit sum of the payload bytes.
//  Ports       : clk      - system clock, rising edge
//                rst_n    - asynchronous active-low reset
//                bus      - telem_pkt_tx_if.slave
//                           send_req/pyld_a/pyld_b/tx_done in,
//                           trmt/tx_data/busy/pkt_done out
//  Parameters  : HDR0, HDR1 - the two header bytes
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module telem_pkt_tx #(
    parameter logic [7:0] HDR0 = 8'hAA,
    parameter logic [7:0] HDR1 = 8'h55
) (
    input  logic           clk,
    input  logic           rst_n,
    telem_pkt_tx_if.slave  bus
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_xmit = 2'd1;
    localparam logic [1:0] c_wait = 2'd2;

`ifdef TELEM_CHKSUM_EN
    localparam logic [2:0] c_last_idx = 3'd6;
`else
    localparam logic [2:0] c_last_idx = 3'd5;
`endif

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [2:0]  r_idx;
    logic [15:0] r_pyld_a;
    logic [15:0] r_pyld_b;
    logic        r_tx_done_q;
    logic [7:0]  r_tx_data;
    logic        r_pkt_done;

    logic        w_tx_done_rise;
    logic        w_accept;
    logic        w_advance;
    logic        w_finish;
    logic [2:0]  w_idx_inc;
    logic [7:0]  w_next_byte;
    logic        w_trmt;
    logic        w_busy;

`ifdef TELEM_CHKSUM_EN
    // Payload bytes plus this value sum to zero modulo 256.
    logic [7:0]  w_chksum;
    assign w_chksum = 8'd0 - (r_pyld_a[15:8] + r_pyld_a[7:0]
                            + r_pyld_b[15:8] + r_pyld_b[7:0]);
`endif

    // Only a fresh 0->1 transition counts as completion; tx_done is a level
    // that stays high from the previous byte until the UART sees trmt.
    assign w_tx_done_rise = bus.tx_done & ~r_tx_done_q;
    assign w_accept       = (r_state == c_idle) & bus.send_req;
    assign w_advance      = (r_state == c_wait) & w_tx_done_rise & (r_idx != c_last_idx);
    assign w_finish       = (r_state == c_wait) & w_tx_done_rise & (r_idx == c_last_idx);
    assign w_idx_inc      = r_idx + 3'd1;

    // Byte for the index being entered on an advance (index 0 is loaded
    // directly with HDR0 on acceptance).
    always_comb begin
        w_next_byte = HDR0;
        case (w_idx_inc)
            3'd1:    w_next_byte = HDR1;
            3'd2:    w_next_byte = r_pyld_a[15:8];
            3'd3:    w_next_byte = r_pyld_a[7:0];
            3'd4:    w_next_byte = r_pyld_b[15:8];
            3'd5:    w_next_byte = r_pyld_b[7:0];
`ifdef TELEM_CHKSUM_EN
            3'd6:    w_next_byte = w_chksum;
`endif
            default: w_next_byte = HDR0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (bus.send_req) begin
                    w_state_next = c_xmit;
                end
            end
            c_xmit: begin
                w_state_next = c_wait;
            end
            c_wait: begin
                if (w_tx_done_rise) begin
                    w_state_next = (r_idx == c_last_idx) ? c_idle : c_xmit;
                end
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_trmt = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            c_xmit:  begin w_trmt = 1'b1; w_busy = 1'b1; end
            c_wait:  begin w_busy = 1'b1; end
            default: begin w_trmt = 1'b0; w_busy = 1'b0; end
        endcase
    end

    // Datapath: payload capture, byte index, registered byte and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= 3'd0;
            r_pyld_a    <= 16'h0000;
            r_pyld_b    <= 16'h0000;
            r_tx_done_q <= 1'b0;
            r_tx_data   <= 8'h00;
            r_pkt_done  <= 1'b0;
        end else begin
            r_tx_done_q <= bus.tx_done;
            r_pkt_done  <= w_finish;
            if (w_accept) begin
                r_pyld_a  <= bus.pyld_a;
                r_pyld_b  <= bus.pyld_b;
                r_idx     <= 3'd0;
                r_tx_data <= HDR0;
            end else if (w_advance) begin
                r_idx     <= w_idx_inc;
                r_tx_data <= w_next_byte;
            end
        end
    end

    assign bus.trmt     = w_trmt;
    assign bus.busy     = w_busy;
    assign bus.tx_data  = r_tx_data;
    assign bus.pkt_done = r_pkt_done;

endmodule

`default_nettype wire

// File: tb/tb_telem_pkt_tx.sv
// ============================================================================
//  Module      : tb_telem_pkt_tx
//  Description : Self-checking bench for telem_pkt_tx. Packets from a vector
//                table are sent through a UART model that raises tx_done 20
//                cycles after each trmt; hand-written sequences cover stale
//                tx_done, mid-packet payload change, ignored request,
//                mid-packet reset and back-to-back requests.
//                Honours TELEM_CHKSUM_EN for the expected packet length.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_telem_pkt_tx;

`ifdef TELEM_CHKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int GAP = 21;   // trmt-to-trmt spacing with the UART model

    typedef struct packed {
        logic [15:0]     a;
        logic [15:0]     b;
        logic [0:6][7:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    telem_pkt_tx_if bus();

    telem_pkt_tx #(
        .HDR0 (8'hAA),
        .HDR1 (8'h55)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total  = 0;
    int passed = 0;

    // Monitor: record every trmt byte and every pkt_done pulse
    logic [7:0] byte_q[$];
    int         trmt_cyc_q[$];
    int         pkt_cyc_q[$];
    logic       pkt_busy_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (bus.trmt === 1'b1) begin
                byte_q.push_back(bus.tx_data);
                trmt_cyc_q.push_back(cyc);
            end
            if (bus.pkt_done === 1'b1) begin
                pkt_cyc_q.push_back(cyc);
                pkt_busy_q.push_back(bus.busy);
            end
        end
    end

    // UART model: tx_done rises 20 cycles after trmt and stays high until the
    // next trmt. In stale mode the old high level lingers one cycle past trmt.
    bit stale_mode = 1'b0;
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.trmt === 1'b1) begin
                if (stale_mode) begin
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                    repeat (GAP - 2) @(negedge clk);
                end else begin
                    bus.tx_done = 1'b0;
                    repeat (GAP - 1) @(negedge clk);
                end
                bus.tx_done = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (byte_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_byte_timeout"}, (byte_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_pkts(input int n, input int budget, input string tag);
        int k = 0;
        while (pkt_cyc_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_pkt_timeout"}, (pkt_cyc_q.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic send_pulse(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.pyld_a   = a;
        bus.pyld_b   = b;
        bus.send_req = 1'b1;
        @(negedge clk);
        bus.send_req = 1'b0;
    endtask

    // Compare one packet recorded since the given queue positions
    task automatic check_packet(input vec_t v, input int bb, input int pb, input string tag);
        logic [31:0] act;
        chk({tag, "_nbytes"}, byte_q.size() - bb, NB);
        for (int i = 0; i < NB; i++) begin
            act = (bb + i < byte_q.size()) ? {24'd0, byte_q[bb + i]} : 32'h1FF;
            chk($sformatf("%s_byte%0d", tag, i), act, {24'd0, v.exp[i]});
        end
        for (int i = 1; i < NB; i++) begin
            act = (bb + i < trmt_cyc_q.size()) ?
                  trmt_cyc_q[bb + i] - trmt_cyc_q[bb + i - 1] : 32'hFFFF_FFFF;
            chk($sformatf("%s_gap%0d", tag, i), act, GAP);
        end
        chk({tag, "_npkts"}, pkt_cyc_q.size() - pb, 1);
        if (pkt_cyc_q.size() > pb && trmt_cyc_q.size() >= bb + NB) begin
            chk({tag, "_done_time"}, pkt_cyc_q[pb] - trmt_cyc_q[bb + NB - 1], GAP);
            chk({tag, "_busy_at_done"}, {31'd0, pkt_busy_q[pb]}, 32'd0);
        end
        chk({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   bb;
        int   pb;

        vecs[0] = '{a: 16'h1234, b: 16'hABCD,
                    exp: {8'hAA, 8'h55, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42}};
        vecs[1] = '{a: 16'h0000, b: 16'h0000,
                    exp: {8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{a: 16'hFFFF, b: 16'hFFFF,
                    exp: {8'hAA, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04}};
        vecs[3] = '{a: 16'h0102, b: 16'h0304,
                    exp: {8'hAA, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6}};

        bus.send_req = 1'b0;
        bus.pyld_a   = 16'h0000;
        bus.pyld_b   = 16'h0000;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_trmt",     {31'd0, bus.trmt},     32'd0);
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_pkt_done", {31'd0, bus.pkt_done}, 32'd0);
        chk("rst_tx_data",  {24'd0, bus.tx_data},  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_trmt",    {31'd0, bus.trmt},    32'd0);
        chk("rel_busy",    {31'd0, bus.busy},    32'd0);
        chk("rel_tx_data", {24'd0, bus.tx_data}, 32'd0);

        // Table-driven packets
        for (int k = 0; k < 4; k++) begin
            bb = byte_q.size();
            pb = pkt_cyc_q.size();
            send_pulse(vecs[k].a, vecs[k].b);
            wait_pkts(pb + 1, 400, $sformatf("vec%0d", k));
            repeat (5) @(negedge clk);
            check_packet(vecs[k], bb, pb, $sformatf("vec%0d", k));
        end

        // Stale tx_done lingering one cycle past trmt
        stale_mode = 1'b1;
        bb = byte_q.size();
        pb = pkt_cyc_q.size();
        send_pulse(16'h1234, 16'hABCD);
        wait_pkts(pb + 1, 400, "stale");
        repeat (5) @(negedge clk);
        check_packet(vecs[0], bb, pb, "stale");
        stale_mode = 1'b0;

        // Payload inputs change mid-packet
        bb = byte_q.size();
        pb = pkt_cyc_q.size();
        send_pulse(16'h1234, 16'hABCD);
        wait_bytes(bb + 2, 100, "pchg");
        bus.pyld_a = 16'hFFFF;
        bus.pyld_b = 16'h0000;
        wait_pkts(pb + 1, 400, "pchg");
        repeat (5) @(negedge clk);
        check_packet(vecs[0], bb, pb, "pchg");

        // Request while busy is dropped
        bb = byte_q.size();
        pb = pkt_cyc_q.size();
        send_pulse(16'h1234, 16'hABCD);
        wait_bytes(bb + 4, 200, "ign");
        @(negedge clk);
        bus.send_req = 1'b1;
        @(negedge clk);
        bus.send_req = 1'b0;
        wait_pkts(pb + 1, 400, "ign");
        repeat (60) @(negedge clk);
        check_packet(vecs[0], bb, pb, "ign");

        // Reset during WAIT of byte 2
        bb = byte_q.size();
        pb = pkt_cyc_q.size();
        send_pulse(16'h1234, 16'hABCD);
        wait_bytes(bb + 3, 200, "rstmid");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_trmt",    {31'd0, bus.trmt},    32'd0);
        chk("rstmid_busy",    {31'd0, bus.busy},    32'd0);
        chk("rstmid_tx_data", {24'd0, bus.tx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rstmid_no_more_trmt", byte_q.size() - bb, 32'd3);
        chk("rstmid_no_pkt_done",  pkt_cyc_q.size() - pb, 32'd0);
        bb = byte_q.size();
        pb = pkt_cyc_q.size();
        send_pulse(16'h1234, 16'hABCD);
        wait_pkts(pb + 1, 400, "rstnew");
        repeat (5) @(negedge clk);
        check_packet(vecs[0], bb, pb, "rstnew");

        // send_req held high across two packets
        bb = byte_q.size();
        pb = pkt_cyc_q.size();
        @(negedge clk);
        bus.pyld_a   = 16'h0102;
        bus.pyld_b   = 16'h0304;
        bus.send_req = 1'b1;
        wait_bytes(bb + NB + 1, 600, "cont");
        bus.send_req = 1'b0;
        wait_pkts(pb + 2, 600, "cont");
        repeat (60) @(negedge clk);
        chk("cont_npkts",  pkt_cyc_q.size() - pb, 32'd2);
        chk("cont_nbytes", byte_q.size() - bb, 2 * NB);
        if (pkt_cyc_q.size() > pb && trmt_cyc_q.size() > bb + NB) begin
            chk("cont_restart_gap", trmt_cyc_q[bb + NB] - pkt_cyc_q[pb], 32'd1);
            chk("cont_hdr0", {24'd0, byte_q[bb + NB]}, 32'h0000_00AA);
            chk("cont_busy_at_done", {31'd0, pkt_busy_q[pb]}, 32'd0);
        end else begin
            chk("cont_records_present", 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
